// File: rtl/cv_pkg.sv
// cv_pkg: shared definitions for the Excess-3 word sequencer.
//   cv_state_t    - sequencer state encoding (IDLE/CLR/SHIFT/DONE)
//   CV_DIGIT_W    - bits per Excess-3 / BCD digit
//   CV_E3_MIN/MAX - legal Excess-3 code range
//   cv_e3_invalid - flags a digit outside the legal range
package cv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CLR,
    SHIFT,
    DONE
  } cv_state_t;

  localparam int unsigned CV_DIGIT_W = 4;
  localparam int unsigned CV_E3_MIN  = 3;
  localparam int unsigned CV_E3_MAX  = 12;

  function automatic logic cv_e3_invalid(input logic [CV_DIGIT_W-1:0] d);
    return (d < CV_DIGIT_W'(CV_E3_MIN)) || (d > CV_DIGIT_W'(CV_E3_MAX));
  endfunction

endpackage

// File: rtl/Lab3_Converter_state_diagram.sv
// Lab3_Converter_state_diagram: bit-serial Excess-3 to BCD converter.
// Digits enter LSB first on X; Z is the Mealy output (X minus 3, serially).
//   X   in  : serial Excess-3 bit
//   Clk in  : clock
//   Rst in  : synchronous reset, active-low (returns to the first-bit state)
//   Z   out : serial BCD bit, combinational from X and state
module Lab3_Converter_state_diagram (
  input  logic X,
  input  logic Clk,
  input  logic Rst,
  output logic Z
);

  // S0: bit0; S1/S2: bit1 no-borrow/borrow; S3/S4: bit2; S5/S6: bit3.
  typedef enum logic [2:0] {
    S0, S1, S2, S3, S4, S5, S6
  } conv_state_t;

  conv_state_t state, state_nxt;

  always_ff @(posedge Clk) begin
    if (!Rst) state <= S0;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = S0;
    case (state)
      S0:      state_nxt = X ? S1 : S2;
      S1:      state_nxt = X ? S3 : S4;
      S2:      state_nxt = S4;
      S3:      state_nxt = S5;
      S4:      state_nxt = X ? S5 : S6;
      S5:      state_nxt = S0;
      S6:      state_nxt = S0;
      default: state_nxt = S0;
    endcase
  end

  always_comb begin
    Z = 1'b0;
    case (state)
      S0, S1, S4, S6: Z = ~X;
      S2, S3, S5:     Z = X;
      default:        Z = 1'b0;
    endcase
  end

endmodule

// File: rtl/cv_word_converter.sv
// cv_word_converter: cv_seq_ctrl paired with one serial converter instance.
//   Clk, Rst               : clock, synchronous active-high reset
//   in_e3/in_valid/in_ready: packed Excess-3 word input handshake
//   out_bcd/out_err/out_valid/out_ready: packed BCD result handshake
module cv_word_converter
  import cv_pkg::*;
#(
  parameter int unsigned NDIGITS = 4
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic [CV_DIGIT_W*NDIGITS-1:0] in_e3,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [CV_DIGIT_W*NDIGITS-1:0] out_bcd,
  output logic                         out_err,
  output logic                         out_valid,
  input  logic                         out_ready
);

  logic conv_x, conv_rst_n, conv_z;

  cv_seq_ctrl #(.NDIGITS(NDIGITS)) u_ctrl (
    .Clk        (Clk),
    .Rst        (Rst),
    .in_e3      (in_e3),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_bcd    (out_bcd),
    .out_err    (out_err),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .conv_x     (conv_x),
    .conv_rst_n (conv_rst_n),
    .conv_z     (conv_z)
  );

  Lab3_Converter_state_diagram u_conv (
    .X   (conv_x),
    .Clk (Clk),
    .Rst (conv_rst_n),
    .Z   (conv_z)
  );

endmodule

// File: rtl/cv_seq_ctrl.sv
// cv_seq_ctrl: shares one serial Excess-3 converter across an NDIGITS word.
// Each digit: one CLR cycle (converter reset) then four SHIFT cycles, LSB first.
//   Clk, Rst               : clock, synchronous active-high reset
//   in_e3/in_valid/in_ready: packed Excess-3 word input handshake
//   out_bcd/out_err        : packed BCD result, invalid-digit flag
//   out_valid/out_ready    : result handshake, held until accepted
//   conv_x/conv_rst_n/conv_z: serial converter interface
module cv_seq_ctrl
  import cv_pkg::*;
#(
  parameter int unsigned NDIGITS = 4
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic [CV_DIGIT_W*NDIGITS-1:0] in_e3,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [CV_DIGIT_W*NDIGITS-1:0] out_bcd,
  output logic                         out_err,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         conv_x,
  output logic                         conv_rst_n,
  input  logic                         conv_z
);

  localparam int unsigned W  = CV_DIGIT_W * NDIGITS;
  localparam int unsigned DW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [DW-1:0] LAST_DIG = DW'(NDIGITS - 1);

  cv_state_t     state, state_nxt;
  logic [W-1:0]  e3_q, res_q;
  logic [DW-1:0] dig_cnt;
  logic [1:0]    bit_cnt;
  logic          err_q;

  logic          accept, last_bit, last_dig, in_err;
  int unsigned   bit_idx;
  logic [W-1:0]  bit_sel;

  assign accept   = in_valid && (state == IDLE);
  assign last_bit = (bit_cnt == 2'd3);
  assign last_dig = (dig_cnt == LAST_DIG);

  always_comb begin
    bit_idx = CV_DIGIT_W * 32'(dig_cnt) + 32'(bit_cnt);
    bit_sel = W'(1) << bit_idx;
    in_err  = 1'b0;
    for (int unsigned i = 0; i < NDIGITS; i++)
      in_err |= cv_e3_invalid(CV_DIGIT_W'(in_e3 >> (CV_DIGIT_W * i)));
  end

  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CLR;
      CLR:     state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = last_dig ? DONE : CLR;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Decoded from registered state/counters only, so conv_z never loops back.
  always_comb begin
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    conv_rst_n = 1'b0;
    conv_x     = 1'b0;
    case (state)
      IDLE:  in_ready = 1'b1;
      SHIFT: begin
        conv_rst_n = 1'b1;
        conv_x     = |(e3_q & bit_sel);
      end
      DONE:  out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      e3_q    <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      dig_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          e3_q    <= in_e3;
          res_q   <= '0;
          err_q   <= in_err;
          dig_cnt <= '0;
          bit_cnt <= '0;
        end
        CLR: bit_cnt <= '0;
        SHIFT: begin
          // Result was cleared on acceptance, so OR-ing in each bit suffices.
          res_q   <= res_q | (conv_z ? bit_sel : '0);
          bit_cnt <= last_bit ? 2'd0 : bit_cnt + 2'd1;
          if (last_bit && !last_dig) dig_cnt <= dig_cnt + DW'(1);
        end
        default: ;
      endcase
    end
  end

  assign out_bcd = res_q;
  assign out_err = err_q;

endmodule

// File: tb/tb_cv_seq_ctrl.sv
module tb_cv_seq_ctrl;

  localparam int unsigned N = 4;

  logic        Clk = 1'b0;
  logic        Rst, in_valid, out_ready;
  logic [15:0] in_e3;
  logic        in_ready, out_err, out_valid, conv_x, conv_rst_n, conv_z;
  logic [15:0] out_bcd;
  logic        w_in_ready, w_out_err, w_out_valid;
  logic [15:0] w_out_bcd;

  cv_seq_ctrl #(.NDIGITS(N)) dut (
    .Clk(Clk), .Rst(Rst), .in_e3(in_e3), .in_valid(in_valid), .in_ready(in_ready),
    .out_bcd(out_bcd), .out_err(out_err), .out_valid(out_valid), .out_ready(out_ready),
    .conv_x(conv_x), .conv_rst_n(conv_rst_n), .conv_z(conv_z)
  );

  Lab3_Converter_state_diagram conv (
    .X(conv_x), .Clk(Clk), .Rst(conv_rst_n), .Z(conv_z)
  );

  cv_word_converter #(.NDIGITS(N)) wrap (
    .Clk(Clk), .Rst(Rst), .in_e3(in_e3), .in_valid(in_valid), .in_ready(w_in_ready),
    .out_bcd(w_out_bcd), .out_err(w_out_err), .out_valid(w_out_valid), .out_ready(out_ready)
  );

  always #5 Clk = ~Clk;

  int unsigned edges = 0;
  always @(posedge Clk) edges++;

  typedef struct {
    logic [15:0] e3;
    logic [15:0] bcd;
    logic        err;
    logic [15:0] mask;
  } vec_t;

  typedef struct {
    logic [15:0] bcd;
    logic        err;
    logic [15:0] mask;
    int unsigned acc_edge;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];
  vec_t cur;
  int   passed = 0;
  int   total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: actual %0h required %0h", name, act, req);
  endtask

  // Scoreboard: push on accepted handshake, pop when a result appears.
  logic prev_ov = 1'b0;
  always @(negedge Clk) begin
    exp_t e;
    if (Rst) begin
      sb.delete();
    end else begin
      if (in_valid && in_ready) begin
        e.bcd = cur.bcd; e.err = cur.err; e.mask = cur.mask; e.acc_edge = edges + 1;
        sb.push_back(e);
      end
      if (out_valid && !prev_ov) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("out_bcd", out_bcd & e.mask, e.bcd & e.mask);
          check("out_err", out_err, e.err);
          check("latency", edges - e.acc_edge, 5 * N);
          check("wrap_valid", w_out_valid, 1'b1);
          check("wrap_bcd", w_out_bcd & e.mask, e.bcd & e.mask);
          check("wrap_err", w_out_err, e.err);
        end
      end
    end
    prev_ov = out_valid;
  end

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  // Drive one word, check the per-cycle converter control pattern and
  // latency; optionally accept the result.
  task automatic send_word(input vec_t v, input bit consume);
    logic [19:0] obs_rst, exp_rst, obs_x, exp_x;
    logic [15:0] tmp;
    logic        early_ov;
    cur = v;
    in_e3 = v.e3;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !in_ready; i++) tick();
    check("in_ready_wait", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    in_e3 = 16'($urandom);
    obs_rst = '0; exp_rst = '0; obs_x = '0; exp_x = '0; early_ov = 1'b0;
    for (int j = 0; j < 20; j++) begin
      obs_rst = {conv_rst_n, obs_rst[19:1]};
      obs_x   = {conv_x, obs_x[19:1]};
      exp_rst = {((j % 5) != 0), exp_rst[19:1]};
      tmp = v.e3 >> (4 * (j / 5) + ((j % 5) == 0 ? 0 : (j % 5) - 1));
      exp_x   = {((j % 5) != 0) && tmp[0], exp_x[19:1]};
      early_ov |= out_valid;
      tick();
    end
    check("conv_rst_n_pattern", obs_rst, exp_rst);
    check("conv_x_pattern", obs_x, exp_x);
    check("out_valid_early", early_ov, 1'b0);
    check("out_valid_at_20", out_valid, 1'b1);
    if (consume) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("in_ready_after_done", in_ready, 1'b1);
    end
  endtask

  task automatic finish_word();
    for (int i = 0; i < 40 && !out_valid; i++) tick();
    check("out_valid_wait", out_valid, 1'b1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int unsigned acc[$];
    vecs.push_back('{16'h6C43, 16'h3910, 1'b0, 16'hFFFF});
    vecs.push_back('{16'h6543, 16'h3210, 1'b0, 16'hFFFF});
    vecs.push_back('{16'h9987, 16'h6654, 1'b0, 16'hFFFF});
    vecs.push_back('{16'hCBA3, 16'h9870, 1'b0, 16'hFFFF});
    vecs.push_back('{16'hC3C3, 16'h9090, 1'b0, 16'hFFFF});
    vecs.push_back('{16'h4F13, 16'h1000, 1'b1, 16'hF00F});
    cur = vecs[0];

    Rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_e3 = '0;
    repeat (2) @(posedge Clk);
    #1;
    Rst = 1'b0;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_bcd", out_bcd, 16'h0);
    check("rst_out_err", out_err, 1'b0);
    check("rst_conv_rst_n", conv_rst_n, 1'b0);
    check("rst_conv_x", conv_x, 1'b0);
    check("rst_wrap_in_ready", w_in_ready, 1'b1);
    tick();

    foreach (vecs[i]) send_word(vecs[i], 1'b1);

    // Backpressure with a pending word: nothing accepted while DONE.
    send_word(vecs[1], 1'b0);
    cur = vecs[0];
    in_e3 = vecs[0].e3;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("bp_out_bcd", out_bcd, 16'h3210);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_out_valid", out_valid, 1'b1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_in_ready_back", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    check("bp_accepted", in_ready, 1'b0);
    finish_word();

    // Reset mid-word discards the partial result and the error flag.
    v = vecs[5];
    cur = v;
    in_e3 = v.e3;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (6) tick();
    check("mid_err_latched", out_err, 1'b1);
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    check("mid_in_ready", in_ready, 1'b1);
    check("mid_out_valid", out_valid, 1'b0);
    check("mid_out_bcd", out_bcd, 16'h0);
    check("mid_out_err", out_err, 1'b0);
    check("mid_conv_rst_n", conv_rst_n, 1'b0);
    repeat (25) begin
      check("mid_no_result", out_valid, 1'b0);
      tick();
    end
    send_word(vecs[0], 1'b1);

    // Throughput with out_ready held high: one word per 5*N+2 cycles.
    cur = vecs[2];
    in_e3 = vecs[2].e3;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (in_ready) acc.push_back(edges);
      tick();
    end
    in_valid = 1'b0;
    repeat (30) tick();
    out_ready = 1'b0;
    check("tp_accepts", acc.size(), 3);
    for (int i = 1; i < acc.size(); i++)
      check("tp_gap", acc[i] - acc[i-1], 5 * N + 2);

    repeat (3) tick();
    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
